// File: rtl/lock_pkg.sv
// ============================================================================
// Module      : lock_pkg
// Description : Shared state encoding, status colours and width helpers for
//               the multi-digit keypad lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED       = 3'd0,
        ST_UNLOCKED     = 3'd1,
        ST_PROG_NEW     = 3'd2,
        ST_PROG_CONFIRM = 3'd3,
        ST_LOCKOUT      = 3'd4
    } lock_state_t;

    localparam logic [2:0] c_rgb_locked   = 3'b000;
    localparam logic [2:0] c_rgb_unlocked = 3'b010;
    localparam logic [2:0] c_rgb_lockout  = 3'b100;
    localparam logic [2:0] c_rgb_prog     = 3'b001;

    // A single-key pad still needs one bit to carry its index.
    function automatic int key_width(input int num_keys);
        return (num_keys > 2) ? $clog2(num_keys) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lock_timer.sv
// ============================================================================
// Module      : lock_timer
// Description : Loadable down-counter; o_done pulses on its final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A restart on the expiry cycle suppresses the stale pulse.
    assign o_done = (r_count == WIDTH'(1)) && !i_start;

endmodule

`default_nettype wire

// File: rtl/multi_digit_lock.sv
// ============================================================================
// Module      : multi_digit_lock
// Description : Keypad code lock with retry lockout, auto-relock and
//               two-pass code reprogramming; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_digit_lock
    import lock_pkg::*;
#(
    parameter int NUM_KEYS         = 4,
    parameter int CODE_LEN         = 4,
    parameter int MAX_TRIES        = 3,
    parameter int LOCKOUT_CYCLES   = 250_000_000,
    parameter int AUTO_LOCK_CYCLES = 0,
    parameter logic [CODE_LEN*key_width(NUM_KEYS)-1:0] DEFAULT_CODE = 8'h1B,
    localparam int KEY_W  = key_width(NUM_KEYS),
    localparam int DCNT_W = cnt_width(CODE_LEN),
    localparam int FCNT_W = cnt_width(MAX_TRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              key_clear,
    input  logic              lock_req,
    input  logic              prog_req,
    output logic              unlocked,
    output logic              lockout,
    output logic              prog_mode,
    output logic [DCNT_W-1:0] digit_cnt,
    output logic [FCNT_W-1:0] fail_cnt,
    output logic              ok_pulse,
    output logic              err_pulse,
    output logic [2:0]        rgb
);

    localparam int CODE_W = CODE_LEN * KEY_W;
    localparam int LOCK_W = cnt_width(LOCKOUT_CYCLES);
    localparam logic [DCNT_W-1:0] c_last_digit = DCNT_W'(CODE_LEN - 1);
    localparam logic [FCNT_W-1:0] c_max_tries  = FCNT_W'(MAX_TRIES);

    lock_state_t       r_state, w_state_nxt;
    logic [CODE_W-1:0] r_entry, w_entry_nxt;
    logic [CODE_W-1:0] r_cand, w_cand_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic [CODE_W-1:0] w_shifted;
    logic [DCNT_W-1:0] r_digit_cnt, w_digit_nxt;
    logic [FCNT_W-1:0] r_fail_cnt, w_fail_nxt;
    logic              r_ok, w_ok_nxt;
    logic              r_err, w_err_nxt;
    logic              r_unlocked, r_lockout, r_prog;
    logic [2:0]        r_rgb, w_rgb_nxt;
    logic              w_key_ok, w_last_digit;
    logic              w_lockout_start, w_lockout_done;
    logic              w_auto_start, w_auto_done;

    assign w_key_ok     = key_valid && (int'(key_code) < NUM_KEYS);
    assign w_last_digit = (r_digit_cnt == c_last_digit);
    assign w_shifted    = (r_entry << KEY_W) | CODE_W'(key_code);

    lock_timer #(
        .WIDTH(LOCK_W)
    ) u_lockout_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load_val(LOCK_W'(LOCKOUT_CYCLES)),
        .i_start   (w_lockout_start),
        .o_done    (w_lockout_done)
    );

    generate
        if (AUTO_LOCK_CYCLES > 0) begin : g_auto_lock
            localparam int AUTO_W = cnt_width(AUTO_LOCK_CYCLES);
            lock_timer #(
                .WIDTH(AUTO_W)
            ) u_auto_timer (
                .clk       (clk),
                .rst       (rst),
                .i_load_val(AUTO_W'(AUTO_LOCK_CYCLES)),
                .i_start   (w_auto_start),
                .o_done    (w_auto_done)
            );
        end else begin : g_no_auto_lock
            logic w_unused_auto_start;
            assign w_unused_auto_start = w_auto_start;
            assign w_auto_done         = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt     = r_state;
        w_entry_nxt     = r_entry;
        w_cand_nxt      = r_cand;
        w_code_nxt      = r_code;
        w_digit_nxt     = r_digit_cnt;
        w_fail_nxt      = r_fail_cnt;
        w_ok_nxt        = 1'b0;
        w_err_nxt       = 1'b0;
        w_lockout_start = 1'b0;
        w_auto_start    = 1'b0;
        w_rgb_nxt       = c_rgb_locked;

        case (r_state)
            ST_LOCKED: begin
                if (key_clear) begin
                    w_entry_nxt = '0;
                    w_digit_nxt = '0;
                end else if (w_key_ok) begin
                    if (w_last_digit) begin
                        w_entry_nxt = '0;
                        w_digit_nxt = '0;
                        if (w_shifted == r_code) begin
                            w_state_nxt  = ST_UNLOCKED;
                            w_fail_nxt   = '0;
                            w_ok_nxt     = 1'b1;
                            w_auto_start = 1'b1;
                        end else begin
                            w_err_nxt  = 1'b1;
                            w_fail_nxt = r_fail_cnt + FCNT_W'(1);
                            if (r_fail_cnt + FCNT_W'(1) == c_max_tries) begin
                                w_state_nxt     = ST_LOCKOUT;
                                w_lockout_start = 1'b1;
                            end
                        end
                    end else begin
                        w_entry_nxt = w_shifted;
                        w_digit_nxt = r_digit_cnt + DCNT_W'(1);
                    end
                end
            end

            ST_UNLOCKED: begin
                if (lock_req) begin
                    w_state_nxt = ST_LOCKED;
                end else if (prog_req) begin
                    w_state_nxt = ST_PROG_NEW;
                end else if (w_auto_done) begin
                    w_state_nxt = ST_LOCKED;
                end
            end

            ST_PROG_NEW, ST_PROG_CONFIRM: begin
                if (lock_req) begin
                    w_state_nxt = ST_LOCKED;
                    w_entry_nxt = '0;
                    w_digit_nxt = '0;
                end else if (key_clear) begin
                    w_entry_nxt = '0;
                    w_digit_nxt = '0;
                end else if (w_key_ok) begin
                    if (w_last_digit) begin
                        w_entry_nxt = '0;
                        w_digit_nxt = '0;
                        if (r_state == ST_PROG_NEW) begin
                            w_cand_nxt  = w_shifted;
                            w_state_nxt = ST_PROG_CONFIRM;
                        end else begin
                            // A confirm mismatch keeps the old code; fail_cnt untouched.
                            if (w_shifted == r_cand) begin
                                w_code_nxt = r_cand;
                                w_ok_nxt   = 1'b1;
                            end else begin
                                w_err_nxt  = 1'b1;
                            end
                            w_state_nxt  = ST_UNLOCKED;
                            w_auto_start = 1'b1;
                        end
                    end else begin
                        w_entry_nxt = w_shifted;
                        w_digit_nxt = r_digit_cnt + DCNT_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (w_lockout_done) begin
                    w_state_nxt = ST_LOCKED;
                    w_fail_nxt  = '0;
                    w_entry_nxt = '0;
                    w_digit_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_LOCKED;
                w_entry_nxt = '0;
                w_digit_nxt = '0;
            end
        endcase

        case (w_state_nxt)
            ST_UNLOCKED:                  w_rgb_nxt = c_rgb_unlocked;
            ST_LOCKOUT:                   w_rgb_nxt = c_rgb_lockout;
            ST_PROG_NEW, ST_PROG_CONFIRM: w_rgb_nxt = c_rgb_prog;
            default:                      w_rgb_nxt = c_rgb_locked;
        endcase
    end

    // Status flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOCKED;
            r_entry     <= '0;
            r_cand      <= '0;
            r_code      <= DEFAULT_CODE;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_unlocked  <= 1'b0;
            r_lockout   <= 1'b0;
            r_prog      <= 1'b0;
            r_rgb       <= c_rgb_locked;
        end else begin
            r_state     <= w_state_nxt;
            r_entry     <= w_entry_nxt;
            r_cand      <= w_cand_nxt;
            r_code      <= w_code_nxt;
            r_digit_cnt <= w_digit_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_ok        <= w_ok_nxt;
            r_err       <= w_err_nxt;
            r_unlocked  <= (w_state_nxt == ST_UNLOCKED);
            r_lockout   <= (w_state_nxt == ST_LOCKOUT);
            r_prog      <= (w_state_nxt == ST_PROG_NEW) || (w_state_nxt == ST_PROG_CONFIRM);
            r_rgb       <= w_rgb_nxt;
        end
    end

    assign unlocked  = r_unlocked;
    assign lockout   = r_lockout;
    assign prog_mode = r_prog;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign ok_pulse  = r_ok;
    assign err_pulse = r_err;
    assign rgb       = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_multi_digit_lock.sv
// ============================================================================
// Module      : tb_multi_digit_lock
// Description : Directed plus randomized stimulus against a queue-based
//               reference model; a monitor compares every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_digit_lock;

    localparam int NUM_KEYS         = 4;
    localparam int CODE_LEN         = 4;
    localparam int MAX_TRIES        = 3;
    localparam int LOCKOUT_CYCLES   = 20;
    localparam int AUTO_LOCK_CYCLES = 50;

    localparam int M_LOCKED       = 0;
    localparam int M_UNLOCKED     = 1;
    localparam int M_PROG_NEW     = 2;
    localparam int M_PROG_CONFIRM = 3;
    localparam int M_LOCKOUT      = 4;

    logic       clk = 1'b0;
    logic       rst, key_valid, key_clear, lock_req, prog_req;
    logic [1:0] key_code;
    logic       unlocked, lockout, prog_mode, ok_pulse, err_pulse;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] rgb;

    multi_digit_lock #(
        .NUM_KEYS        (NUM_KEYS),
        .CODE_LEN        (CODE_LEN),
        .MAX_TRIES       (MAX_TRIES),
        .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
        .AUTO_LOCK_CYCLES(AUTO_LOCK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_clear(key_clear),
        .lock_req (lock_req),
        .prog_req (prog_req),
        .unlocked (unlocked),
        .lockout  (lockout),
        .prog_mode(prog_mode),
        .digit_cnt(digit_cnt),
        .fail_cnt (fail_cnt),
        .ok_pulse (ok_pulse),
        .err_pulse(err_pulse),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;

    // Expected output vector: {unlocked, lockout, prog, digit_cnt, fail_cnt, ok, err, rgb}
    logic [12:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: the code and entries are plain digit lists.
    int m_mode;
    int m_code[CODE_LEN];
    int m_cand[CODE_LEN];
    int m_entry[$];
    int m_fails;
    int m_timer;

    function automatic bit entry_matches(input int target[CODE_LEN]);
        for (int i = 0; i < CODE_LEN; i++)
            if (m_entry[i] != target[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit kv, input int kc,
                              input bit clr, input bit lr, input bit pr);
        bit ok = 1'b0;
        bit err = 1'b0;
        bit key = kv && (kc < NUM_KEYS);
        logic [2:0] col;
        if (r) begin
            m_mode  = M_LOCKED;
            m_code  = '{0, 1, 2, 3};
            m_entry.delete();
            m_fails = 0;
            m_timer = 0;
        end else begin
            case (m_mode)
                M_LOCKED: begin
                    if (clr) m_entry.delete();
                    else if (key) begin
                        m_entry.push_back(kc);
                        if (m_entry.size() == CODE_LEN) begin
                            if (entry_matches(m_code)) begin
                                m_mode = M_UNLOCKED; m_fails = 0; ok = 1'b1; m_timer = 0;
                            end else begin
                                err = 1'b1;
                                m_fails++;
                                if (m_fails == MAX_TRIES) begin
                                    m_mode = M_LOCKOUT; m_timer = 0;
                                end
                            end
                            m_entry.delete();
                        end
                    end
                end
                M_UNLOCKED: begin
                    if (lr) m_mode = M_LOCKED;
                    else if (pr) m_mode = M_PROG_NEW;
                    else begin
                        m_timer++;
                        if (m_timer == AUTO_LOCK_CYCLES) m_mode = M_LOCKED;
                    end
                end
                M_PROG_NEW, M_PROG_CONFIRM: begin
                    if (lr) begin
                        m_mode = M_LOCKED; m_entry.delete();
                    end else if (clr) m_entry.delete();
                    else if (key) begin
                        m_entry.push_back(kc);
                        if (m_entry.size() == CODE_LEN) begin
                            if (m_mode == M_PROG_NEW) begin
                                for (int i = 0; i < CODE_LEN; i++) m_cand[i] = m_entry[i];
                                m_mode = M_PROG_CONFIRM;
                            end else begin
                                if (entry_matches(m_cand)) begin
                                    m_code = m_cand; ok = 1'b1;
                                end else err = 1'b1;
                                m_mode = M_UNLOCKED; m_timer = 0;
                            end
                            m_entry.delete();
                        end
                    end
                end
                default: begin
                    m_timer++;
                    if (m_timer == LOCKOUT_CYCLES) begin
                        m_mode = M_LOCKED; m_fails = 0;
                    end
                end
            endcase
        end
        col = (m_mode == M_UNLOCKED) ? 3'b010 :
              (m_mode == M_LOCKOUT)  ? 3'b100 :
              (m_mode == M_PROG_NEW || m_mode == M_PROG_CONFIRM) ? 3'b001 : 3'b000;
        exp_q.push_back({m_mode == M_UNLOCKED, m_mode == M_LOCKOUT,
                         m_mode == M_PROG_NEW || m_mode == M_PROG_CONFIRM,
                         3'(m_entry.size()), 2'(m_fails), ok, err, col});
    endtask

    task automatic step(input bit r, input bit kv, input int kc,
                        input bit clr, input bit lr, input bit pr);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = 2'(kc);
        key_clear = clr; lock_req = lr; prog_req = pr;
        model_step(r, kv, kc, clr, lr, pr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input int k);
        step(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_lock();
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_prog();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one expected vector is consumed per registered output cycle.
    initial begin
        logic [12:0] exp_v;
        logic [12:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got = {unlocked, lockout, prog_mode, digit_cnt, fail_cnt,
                       ok_pulse, err_pulse, rgb};
                compared++;
                if (got !== exp_v) begin
                    mismatched++;
                    $display("FAIL outputs cycle %0d: got %b required %b (unl,lko,prg,dcnt,fcnt,ok,err,rgb)",
                             cycle, got, exp_v);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, compared %0d", compared);
        $fatal(1, "timeout");
    end

    initial begin
        int kc;
        bit kv, clr, lr, pr, r;
        rst = 1'b1; key_valid = 1'b0; key_code = 2'd0;
        key_clear = 1'b0; lock_req = 1'b0; prog_req = 1'b0;

        do_reset(); do_reset(); idle(1);

        enter(0, 1, 2, 3); idle(2);
        do_lock();
        repeat (3) begin enter(3, 3, 3, 3); idle(1); end
        press(0); press(1); enter(0, 1, 2, 3); idle(20);

        enter(0, 1, 2, 3); do_prog();
        enter(2, 2, 1, 1); enter(2, 2, 1, 1); idle(1);
        do_lock(); enter(2, 2, 1, 1); do_lock(); enter(0, 1, 2, 3); idle(1);

        do_reset(); enter(0, 1, 2, 3); do_prog();
        enter(2, 2, 1, 1); enter(1, 1, 2, 2); idle(1);
        do_lock(); enter(0, 1, 2, 3); do_lock();

        press(0); press(1); step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); idle(1);
        enter(0, 1, 2, 3); idle(55);

        enter(0, 1, 2, 3); step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1); idle(1);
        press(0); step(1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0); enter(0, 1, 2, 3); do_lock();

        repeat (3) enter(3, 3, 3, 3);
        idle(5); do_reset(); idle(1); enter(0, 1, 2, 3); do_lock();

        enter(0, 1, 2, 3); do_prog(); press(2); press(2); do_lock();
        enter(0, 1, 2, 3); do_lock();

        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 999) < 4);
            clr = ($urandom_range(0, 99) < 4);
            lr  = ($urandom_range(0, 99) < 3);
            pr  = ($urandom_range(0, 99) < 5);
            kv  = ($urandom_range(0, 99) < 60);
            kc  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 70) begin
                if (m_mode == M_LOCKED) kc = m_code[m_entry.size()];
                else if (m_mode == M_PROG_CONFIRM) kc = m_cand[m_entry.size()];
            end
            step(r, kv, kc, clr, lr, pr);
        end
        idle(2);

        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
